sixteen_bit_adder: RTL and testbench

- Registered 16-bit unsigned/two's-complement adder that also produces ALU-style status flags: carry, sign, parity, overflow and zero.
- It is the datapath add stage of a small ALU or CPU execute unit.
- Operands are captured on a valid strobe; the result and all flags appear on registered outputs one clock later.

---
 rtl/sixteen_bit_adder_pkg.sv | 33 +++
 rtl/sixteen_bit_adder_core.sv | 23 ++
 rtl/sixteen_bit_adder.sv | 71 +++++++
 tb/tb_sixteen_bit_adder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sixteen_bit_adder_pkg.sv
// Shared definitions for the registered adder: default width, flag bundle and
// the flag derivation used by the combinational core.
package sixteen_bit_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef struct packed {
        logic carry;
        logic sign;
        logic parity;
        logic overflow;
        logic zero;
    } flags_t;

    // Works on the few summary bits of an add so it stays independent of WIDTH.
    function automatic flags_t calc_flags(
        input logic a_msb,
        input logic b_msb,
        input logic carry_out,
        input logic sum_msb,
        input logic sum_parity,
        input logic sum_is_zero
    );
        flags_t f;
        f.carry    = carry_out;
        f.sign     = sum_msb;
        f.parity   = sum_parity;
        f.overflow = (a_msb == b_msb) && (sum_msb != a_msb);
        f.zero     = sum_is_zero;
        return f;
    endfunction

endpackage

// File: rtl/sixteen_bit_adder_core.sv
// Purely combinational add with status flags; no carry-in.
module sixteen_bit_adder_core
    import sixteen_bit_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output flags_t           flags
);

    logic [WIDTH:0] full;

    always_comb begin
        full  = {1'b0, a} + {1'b0, b};
        sum   = full[WIDTH-1:0];
        flags = calc_flags(a[WIDTH-1], b[WIDTH-1], full[WIDTH],
                           full[WIDTH-1], ^full[WIDTH-1:0],
                           full[WIDTH-1:0] == '0);
    end

endmodule

// File: rtl/sixteen_bit_adder.sv
// Register stage around the adder core: captures one operation per cycle on
// in_valid and presents sum and flags one clock later.
module sixteen_bit_adder
    import sixteen_bit_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             sign,
    output logic             parity,
    output logic             overflow,
    output logic             zero
);

    logic [WIDTH-1:0] core_sum;
    flags_t           core_flags;
    logic [WIDTH-1:0] sum_q;
    flags_t           flags_q;
    logic             out_valid_q;
    logic             armed;
    logic             accept;

    sixteen_bit_adder_core #(.WIDTH(WIDTH)) u_core (
        .a     (a),
        .b     (b),
        .sum   (core_sum),
        .flags (core_flags)
    );

    // armed stays low through the first edge after reset release, so the
    // inputs present in the release cycle are never accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    assign accept = in_valid && armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                sum_q   <= core_sum;
                flags_q <= core_flags;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = flags_q.carry;
    assign sign      = flags_q.sign;
    assign parity    = flags_q.parity;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;

endmodule

// File: tb/tb_sixteen_bit_adder.sv
// Bench for sixteen_bit_adder: directed vector table, hold/reset sequences and
// a long random back-to-back run against an arithmetic reference model.
module tb_sixteen_bit_adder;

    localparam int W  = 16;
    localparam int RW = W + 6; // {sum, carry, sign, parity, overflow, zero, out_valid}

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         carry;
    logic         sign;
    logic         parity;
    logic         overflow;
    logic         zero;

    int checks   = 0;
    int failures = 0;

    logic [RW-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         carry;
        logic         sign;
        logic         parity;
        logic         overflow;
        logic         zero;
    } vec_t;

    vec_t vecs[4];

    sixteen_bit_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .sum       (sum),
        .carry     (carry),
        .sign      (sign),
        .parity    (parity),
        .overflow  (overflow),
        .zero      (zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] observed();
        return {sum, carry, sign, parity, overflow, zero, out_valid};
    endfunction

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic logic [RW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        int           u;
        int           s;
        logic [W-1:0] r;
        u = int'(x) + int'(y);
        s = int'($signed(x)) + int'($signed(y));
        r = u % 65536;
        return {r, u > 65535, r >= 16'h8000, ($countones(r) % 2) == 1,
                (s > 32767) || (s < -32768), r == 0, 1'b1};
    endfunction

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got sum=%h c=%b s=%b p=%b v=%b z=%b ov=%b expected sum=%h c=%b s=%b p=%b v=%b z=%b ov=%b",
                     name, act[RW-1:6], act[5], act[4], act[3], act[2], act[1], act[0],
                     exp[RW-1:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = v;
        a        = x;
        b        = y;
    endtask

    initial begin
        logic [RW-1:0] e;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;

        vecs[0] = '{16'h8FFF, 16'h8000, 16'h0FFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'hFFFE, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        drive(1'b0, '0, '0);
        rst = 1'b0;
        #1 rst = 1'b1;
        #2 check("reset_state", observed(), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // directed vector table
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b);
            @(negedge clk);
            drive(1'b0, '0, '0);
            e = {vecs[i].sum, vecs[i].carry, vecs[i].sign, vecs[i].parity,
                 vecs[i].overflow, vecs[i].zero, 1'b1};
            check($sformatf("vec%0d", i), observed(), e);
        end

        // hold for three idle cycles after 7FFF+0001
        e = {16'h8000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d", i), observed(), e);
        end

        // asynchronous reset mid-cycle after a valid op
        drive(1'b1, 16'h1234, 16'h0001);
        @(negedge clk);
        drive(1'b0, '0, '0);
        check("pre_reset_op", observed(), {16'h1235, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        #2 rst = 1'b1;
        #1 check("async_reset", observed(), '0);
        repeat (2) @(negedge clk);
        check("reset_held", observed(), '0);
        // inputs presented while rst releases must be ignored
        drive(1'b1, 16'h0005, 16'h0005);
        rst = 1'b0;
        @(negedge clk);
        check("release_ignored", observed(), '0);
        drive(1'b1, 16'h0000, 16'h0000);
        @(negedge clk);
        drive(1'b0, '0, '0);
        check("post_reset_zero", observed(), {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});

        // random back-to-back stream, scoreboarded one cycle later
        for (int i = 0; i < 10000; i++) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("random", observed(), e);
            end
            ra = W'($urandom_range(0, 65535));
            rb = W'($urandom_range(0, 65535));
            if (i % 16 == 0) rb = W'(-int'(ra)); // bias toward zero/carry corners
            drive(1'b1, ra, rb);
            exp_q.push_back(model(ra, rb));
            @(negedge clk);
        end
        drive(1'b0, '0, '0);
        e = exp_q.pop_front();
        check("random_last", observed(), e);
        @(negedge clk);
        check("random_idle", observed(), {e[RW-1:1], 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
